// File: rtl/mem_packet_pkg.sv
// Shared types and constants for the packet reader.
// Optional preamble/SFD insertion is enabled by defining MEM_PACKET_READER_PREAMBLE_EN.
package mem_packet_pkg;

`ifdef MEM_PACKET_READER_PREAMBLE_EN
    typedef enum logic [2:0] {IDLE, POP, LOAD, READ, GAP, PRE} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, LOAD, READ, GAP} state_t;
`endif

    localparam logic [7:0] lpPREAMBLE     = 8'h55;
    localparam logic [7:0] lpSFD          = 8'hD5;
    localparam int         lpPREAMBLE_CNT = 7;
    localparam int         lpIFG_DEFAULT  = 12;

endpackage

// File: rtl/mem_rd_ptr.sv
// Wrapping read pointer for the packet memory: step by one, or skip a whole
// length modulo the memory depth (used to discard illegal packets).
module mem_rd_ptr #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDEPTH      = 3072,
    parameter int pLEN_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   add,
    input  logic [pLEN_WIDTH-1:0]  len,
    output logic [pADDR_WIDTH-1:0] ptr
);

    localparam int SW = ((pADDR_WIDTH > pLEN_WIDTH) ? pADDR_WIDTH : pLEN_WIDTH) + 1;
    localparam logic [SW-1:0]          DEPTH_S  = SW'(pDEPTH);
    localparam logic [pADDR_WIDTH-1:0] LAST_PTR = pADDR_WIDTH'(pDEPTH - 1);

    logic [SW-1:0]          sum;
    logic [pADDR_WIDTH-1:0] ptr_nxt;

    // A length is always below the depth, so one conditional subtract is a full modulo.
    always_comb begin
        sum = SW'(ptr) + SW'(len);
        if (sum >= DEPTH_S) begin
            sum = sum - DEPTH_S;
        end
        ptr_nxt = ptr;
        if (add) begin
            ptr_nxt = pADDR_WIDTH'(sum);
        end else if (inc) begin
            ptr_nxt = (ptr == LAST_PTR) ? '0 : ptr + pADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mem_packet_reader.sv
// Drains packets from the packet memory into a contiguous transmit stream with an
// inter-frame gap. Define MEM_PACKET_READER_PREAMBLE_EN to prepend 7x0x55 + 0xD5.
module mem_packet_reader
    import mem_packet_pkg::*;
#(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
    parameter int pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
    parameter int pADDR_WIDTH        = $clog2(pDEPTH_RAM),
    parameter int pIFG_CYCLES        = lpIFG_DEFAULT
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   i_fifo_empty,
    input  logic [pFIFO_WIDTH-1:0] i_fifo_len,
    output logic                   o_fifo_rd,
    output logic [pADDR_WIDTH-1:0] o_reg_read_addr,
    input  logic [pDATA_WIDTH-1:0] i_reg_data,
    output logic [pDATA_WIDTH-1:0] o_tx_d,
    output logic                   o_tx_dv,
    output logic                   o_len_err,
    output logic                   o_busy
);

    localparam int GW = $clog2(pIFG_CYCLES + 2);
    localparam logic [GW-1:0]          GAP_LAST = GW'((pIFG_CYCLES >= 2) ? pIFG_CYCLES - 2 : 0);
    localparam logic [pFIFO_WIDTH-1:0] MAX_LEN  = pFIFO_WIDTH'(pMAX_PACKET_LENGHT);

    state_t                 state, state_nxt;
    logic [pFIFO_WIDTH-1:0] len_q, len_nxt;
    logic [pFIFO_WIDTH-1:0] cnt, cnt_nxt;
    logic [GW-1:0]          gap_cnt, gap_nxt;
    logic                   issue, ptr_inc, ptr_add, len_err_nxt;
    logic [pADDR_WIDTH-1:0] ptr;
    logic                   vld_p1;
    logic                   pre_vld_p1;
    logic [pDATA_WIDTH-1:0] pre_byte_p1;

`ifdef MEM_PACKET_READER_PREAMBLE_EN
    logic                   pre_vld;
    logic [pDATA_WIDTH-1:0] pre_byte;
`endif

    mem_rd_ptr #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDEPTH     (pDEPTH_RAM),
        .pLEN_WIDTH (pFIFO_WIDTH)
    ) u_rd_ptr (
        .clk  (iclk),
        .rst_n(i_rst),
        .inc  (ptr_inc),
        .add  (ptr_add),
        .len  (i_fifo_len),
        .ptr  (ptr)
    );

    assign o_reg_read_addr = ptr;
    assign o_fifo_rd       = (state == POP);
    assign o_busy          = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        cnt_nxt     = cnt;
        gap_nxt     = gap_cnt;
        issue       = 1'b0;
        ptr_inc     = 1'b0;
        ptr_add     = 1'b0;
        len_err_nxt = 1'b0;
`ifdef MEM_PACKET_READER_PREAMBLE_EN
        pre_vld     = 1'b0;
        pre_byte    = pDATA_WIDTH'(lpPREAMBLE);
`endif
        case (state)
            IDLE: if (!i_fifo_empty) state_nxt = POP;
            POP:  state_nxt = LOAD;
            LOAD: begin
                len_nxt = i_fifo_len;
                cnt_nxt = '0;
                gap_nxt = '0;
                if (i_fifo_len == '0) begin
                    state_nxt = IDLE;
                end else if (i_fifo_len > MAX_LEN) begin
                    len_err_nxt = 1'b1;
                    ptr_add     = 1'b1;
                    state_nxt   = IDLE;
                end else begin
`ifdef MEM_PACKET_READER_PREAMBLE_EN
                    state_nxt = PRE;
`else
                    state_nxt = READ;
`endif
                end
            end
`ifdef MEM_PACKET_READER_PREAMBLE_EN
            PRE: begin
                pre_vld = 1'b1;
                cnt_nxt = cnt + pFIFO_WIDTH'(1);
                if (cnt == pFIFO_WIDTH'(lpPREAMBLE_CNT)) begin
                    pre_byte  = pDATA_WIDTH'(lpSFD);
                    cnt_nxt   = '0;
                    state_nxt = READ;
                end
            end
`endif
            READ: begin
                issue   = 1'b1;
                ptr_inc = 1'b1;
                cnt_nxt = cnt + pFIFO_WIDTH'(1);
                if (cnt == len_q - pFIFO_WIDTH'(1)) state_nxt = GAP;
            end
            // The gap is timed from the first idle output cycle; the IDLE cycle closes it.
            GAP: begin
                if (!o_tx_dv) begin
                    if (gap_cnt >= GAP_LAST) state_nxt = IDLE;
                    else                     gap_nxt   = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            o_len_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            cnt       <= cnt_nxt;
            gap_cnt   <= gap_nxt;
            o_len_err <= len_err_nxt;
        end
    end

    // Stage p1: issue flag aligned with the memory read latency
    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) vld_p1 <= 1'b0;
        else        vld_p1 <= issue;
    end

`ifdef MEM_PACKET_READER_PREAMBLE_EN
    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            pre_vld_p1  <= 1'b0;
            pre_byte_p1 <= '0;
        end else begin
            pre_vld_p1  <= pre_vld;
            pre_byte_p1 <= pre_byte;
        end
    end
`else
    assign pre_vld_p1  = 1'b0;
    assign pre_byte_p1 = '0;
`endif

    // Stage p2: registered transmit outputs
    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx_dv <= 1'b0;
            o_tx_d  <= '0;
        end else begin
            o_tx_dv <= vld_p1 | pre_vld_p1;
            o_tx_d  <= pre_vld_p1 ? pre_byte_p1 : i_reg_data;
        end
    end

endmodule

// File: tb/tb_mem_packet_reader.sv
// Self-checking bench for mem_packet_reader: FIFO and memory models, an event
// monitor and a packet-level reference that predicts stream, timing and pointer.
module tb_mem_packet_reader;

    localparam int DW    = 8;
    localparam int MAXL  = 1536;
    localparam int FW    = $clog2(MAXL);
    localparam int DEPTH = 2 * MAXL;
    localparam int AW    = $clog2(DEPTH);
    localparam int IFG   = 12;
`ifdef MEM_PACKET_READER_PREAMBLE_EN
    localparam int PRE_N = 8;
`else
    localparam int PRE_N = 0;
`endif

    logic          iclk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_fifo_empty;
    logic [FW-1:0] i_fifo_len = '0;
    logic          o_fifo_rd;
    logic [AW-1:0] o_reg_read_addr;
    logic [DW-1:0] i_reg_data = '0;
    logic [DW-1:0] o_tx_d;
    logic          o_tx_dv, o_len_err, o_busy;

    mem_packet_reader #(
        .pDATA_WIDTH(DW), .pMAX_PACKET_LENGHT(MAXL), .pIFG_CYCLES(IFG)
    ) dut (
        .iclk(iclk), .i_rst(i_rst), .i_fifo_empty(i_fifo_empty), .i_fifo_len(i_fifo_len),
        .o_fifo_rd(o_fifo_rd), .o_reg_read_addr(o_reg_read_addr), .i_reg_data(i_reg_data),
        .o_tx_d(o_tx_d), .o_tx_dv(o_tx_dv), .o_len_err(o_len_err), .o_busy(o_busy)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    logic [7:0] mem [DEPTH];
    always @(posedge iclk) i_reg_data <= mem[o_reg_read_addr];

    int flen [256];
    int wr_idx = 0;
    int rd_idx = 0;
    assign i_fifo_empty = (wr_idx == rd_idx);
    always @(posedge iclk) begin
        if (o_fifo_rd) begin
            i_fifo_len <= FW'(flen[rd_idx % 256]);
            rd_idx     <= rd_idx + 1;
        end
    end

    int         rd_q[$];
    int         err_q[$];
    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         last_busy = -1;
    always @(negedge iclk) begin
        if (o_fifo_rd) rd_q.push_back(cyc);
        if (o_len_err) err_q.push_back(cyc);
        if (o_tx_dv) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(o_tx_d);
        end
        if (o_busy) last_busy <= cyc;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge iclk);
        #1;
    endtask

    function automatic int get_dat(input int idx);
        if (idx >= 0 && idx < dv_dat.size()) return int'(dv_dat[idx]);
        return -1;
    endfunction

    function automatic int get_cyc(input int q_sel, input int idx);
        if (q_sel == 0) return (idx >= 0 && idx < rd_q.size())   ? rd_q[idx]   : -1;
        else            return (idx >= 0 && idx < dv_cyc.size()) ? dv_cyc[idx] : -1;
    endfunction

    // Reference model state: expected read pointer and last predicted dv cycle.
    int ptr_m = 0;
    int last_dv_m = 0;
    int plan [16];
    int plan_n = 0;
    int rd_base, dv_base, err_base;

    task automatic begin_plan;
        rd_base  = rd_q.size();
        dv_base  = dv_cyc.size();
        err_base = err_q.size();
    endtask

    task automatic push_plan;
        for (int i = 0; i < plan_n; i++) begin
            flen[wr_idx % 256] = plan[i];
            wr_idx = wr_idx + 1;
        end
    endtask

    function automatic int exp_byte(input int start, input int i);
        if (i < PRE_N - 1) return 8'h55;
        if (i == PRE_N - 1) return 8'hD5;
        return int'(mem[(start + i - PRE_N) % DEPTH]);
    endfunction

    task automatic finish_plan(input string tag);
        int budget, k, dv_i, t, tend, len, exp_n, n, bad, ne, exp_next;
        bit done, legal;
        budget = 100;
        for (int i = 0; i < plan_n; i++) budget += plan[i] + 24;
        done = 0;
        k = 0;
        while (k < budget && !done) begin
            tick();
            if (rd_q.size() - rd_base >= plan_n && !o_busy) done = 1;
            k++;
        end
        check({tag, "_completes"}, int'(done), 1);
        dv_i = dv_base;
        exp_next = 0;
        for (int p = 0; p < plan_n && rd_base + p < rd_q.size(); p++) begin
            t     = rd_q[rd_base + p];
            tend  = (rd_base + p + 1 < rd_q.size() && p + 1 < plan_n) ? rd_q[rd_base + p + 1] : cyc + 1;
            len   = plan[p];
            legal = (len >= 1 && len <= MAXL);
            exp_n = legal ? len + PRE_N : 0;
            if (p > 0) check($sformatf("%s_p%0d_rd_cycle", tag, p), t, exp_next);
            n = 0;
            bad = 0;
            while (dv_i < dv_cyc.size() && dv_cyc[dv_i] < tend) begin
                if (dv_cyc[dv_i] < t || n >= exp_n) bad++;
                else if (dv_cyc[dv_i] != t + 4 + n || int'(dv_dat[dv_i]) != exp_byte(ptr_m, n)) bad++;
                if (dv_cyc[dv_i] >= t) n++;
                dv_i++;
            end
            ne = 0;
            foreach (err_q[j]) if (j >= err_base && err_q[j] >= t && err_q[j] < tend) ne++;
            check($sformatf("%s_p%0d_len%0d_dv_count", tag, p, len), n, exp_n);
            check($sformatf("%s_p%0d_len%0d_stream_errors", tag, p, len), bad, 0);
            check($sformatf("%s_p%0d_len%0d_len_err_pulses", tag, p, len), ne, (len > MAXL) ? 1 : 0);
            if (len != 0) ptr_m = (ptr_m + len) % DEPTH;
            if (legal) begin
                last_dv_m = t + 3 + exp_n;
                exp_next  = last_dv_m + IFG + 1;
            end else begin
                exp_next = t + 3;
            end
        end
        check({tag, "_rd_count"}, rd_q.size() - rd_base, plan_n);
        check({tag, "_read_ptr"}, int'(o_reg_read_addr), ptr_m);
    endtask

    task automatic do_reset;
        i_rst = 1'b0;
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        ptr_m = 0;
    endtask

    typedef struct {
        int len;
        int exp_dv;
        int exp_err;
        int exp_adv;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int start, b_dv, b_err, r, n0, d0;
        tbl[0] = '{1,    1,    0, 1};
        tbl[1] = '{0,    0,    0, 0};
        tbl[2] = '{2000, 0,    1, 2000};
        tbl[3] = '{1536, 1536, 0, 1536};
        tbl[4] = '{1537, 0,    1, 1537};
        tbl[5] = '{2047, 0,    1, 2047};
        tbl[6] = '{7,    7,    0, 7};
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);

        // Reset held with a non-empty FIFO
        begin_plan();
        plan[0] = 64;
        plan_n  = 1;
        push_plan();
        repeat (5) tick();
        check("rst_fifo_rd", int'(o_fifo_rd), 0);
        check("rst_tx_dv", int'(o_tx_dv), 0);
        check("rst_tx_d", int'(o_tx_d), 0);
        check("rst_len_err", int'(o_len_err), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_addr", int'(o_reg_read_addr), 0);
        check("rst_no_pop", rd_q.size(), 0);
        i_rst = 1'b1;
        finish_plan("single");
        check("single_first_dv_after_rd", get_cyc(1, dv_base) - get_cyc(0, rd_base), 4);
        check("single_byte_0x3f", get_dat(dv_base + PRE_N + 63), 8'h3F);
        check("single_busy_drop", last_busy, last_dv_m + 11);

        // Back-to-back from a fresh pointer
        do_reset();
        begin_plan();
        plan[0] = 64;
        plan[1] = 100;
        plan_n  = 2;
        push_plan();
        finish_plan("b2b");
        check("b2b_rd_gap", get_cyc(0, rd_base + 1) - get_cyc(1, dv_base + PRE_N + 63), 13);
        check("b2b_pkt2_first", get_dat(dv_base + 2 * PRE_N + 64), int'(mem[64]));
        check("b2b_pkt2_last", get_dat(dv_base + 2 * PRE_N + 163), int'(mem[163]));

        // Table of single-length vectors
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
        foreach (tbl[i]) begin
            start = ptr_m;
            b_dv  = dv_cyc.size();
            b_err = err_q.size();
            begin_plan();
            plan[0] = tbl[i].len;
            plan_n  = 1;
            push_plan();
            finish_plan($sformatf("vec%0d", i));
            check($sformatf("vec%0d_dv_total", i), dv_cyc.size() - b_dv,
                  tbl[i].exp_dv + ((tbl[i].exp_dv > 0) ? PRE_N : 0));
            check($sformatf("vec%0d_err_total", i), err_q.size() - b_err, tbl[i].exp_err);
            check($sformatf("vec%0d_ptr", i), int'(o_reg_read_addr), (start + tbl[i].exp_adv) % DEPTH);
        end

        // Randomized packet trains
        for (int rnd = 0; rnd < 6; rnd++) begin
            plan_n = $urandom_range(1, 4);
            for (int i = 0; i < plan_n; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      plan[i] = 0;
                else if (r == 1) plan[i] = $urandom_range(MAXL + 1, (1 << FW) - 1);
                else if (r == 2) plan[i] = $urandom_range(1, MAXL);
                else             plan[i] = $urandom_range(1, 120);
            end
            begin_plan();
            push_plan();
            finish_plan($sformatf("rnd%0d", rnd));
        end

        // Reset in the middle of a packet
        begin_plan();
        plan[0] = 64;
        plan_n  = 1;
        push_plan();
        r = 0;
        while (r < 300 && dv_cyc.size() - dv_base < PRE_N + 10) begin
            tick();
            r++;
        end
        check("midrst_reached_byte10", dv_cyc.size() - dv_base, PRE_N + 10);
        i_rst = 1'b0;
        #1;
        check("midrst_dv_now", int'(o_tx_dv), 0);
        check("midrst_ptr_now", int'(o_reg_read_addr), 0);
        check("midrst_busy_now", int'(o_busy), 0);
        repeat (2) tick();
        i_rst = 1'b1;
        ptr_m = 0;
        n0 = rd_q.size();
        d0 = dv_cyc.size();
        repeat (30) tick();
        check("midrst_no_pop_after", rd_q.size() - n0, 0);
        check("midrst_no_tail", dv_cyc.size() - d0, 0);
        check("midrst_idle", int'(o_busy), 0);

        // Walk pointer to 3040 via illegal lengths, then a wrapping packet
        begin_plan();
        plan[0] = 2047;
        plan[1] = 2047;
        plan[2] = 2018;
        plan[3] = 64;
        plan_n  = 4;
        push_plan();
        finish_plan("wrap");
        check("wrap_first_byte", get_dat(dv_base + PRE_N), int'(mem[3040]));
        check("wrap_byte_at_0", get_dat(dv_base + PRE_N + 32), int'(mem[0]));
        check("wrap_contiguous", get_cyc(1, dv_base + PRE_N + 63) - get_cyc(1, dv_base), PRE_N + 63);
        check("wrap_err_pulses", err_q.size() - err_base, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
